// File: rtl/entropy_pkg.sv
// Shared constants and types for the entropy harvesting path.
package entropy_pkg;

    localparam int unsigned WIDTH_DEF      = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned REP_LIMIT_DEF  = 64;

    // Von Neumann extractor: which half of a sample pair is expected next.
    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } ext_state_t;

endpackage

// File: rtl/entropy_harvester_if.sv
// Output stream and status bundle of the entropy harvester.
interface entropy_harvester_if #(
    parameter int unsigned WIDTH   = entropy_pkg::WIDTH_DEF,
    parameter int unsigned LEVEL_W = $clog2(entropy_pkg::FIFO_DEPTH_DEF) + 1
);
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [LEVEL_W-1:0] fifo_level;
    logic               health_fail;
    logic               drop_pulse;

    modport master (
        output out_data, out_valid, fifo_level, health_fail, drop_pulse,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, fifo_level, health_fail, drop_pulse,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered first-word fall-through head,
// flush, and a one-cycle drop flag for pushes refused while full.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LEVEL_W-1:0] count;

    logic               pop_c;
    logic               push_c;
    logic [LEVEL_W-1:0] after_pop_c;
    logic [PTR_W-1:0]   rd_next_c;

    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    always_comb begin
        pop_c       = pop && (count != '0);
        push_c      = push && ((count != LEVEL_W'(DEPTH)) || pop_c);
        after_pop_c = count - LEVEL_W'(pop_c);
        rd_next_c   = rd_ptr + PTR_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head register reloads from storage, or from the incoming word when the
    // FIFO would otherwise be empty; it holds its last value when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
            drop   <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            drop   <= 1'b0;
        end else begin
            drop   <= push && !push_c;
            rd_ptr <= rd_next_c;
            count  <= after_pop_c + LEVEL_W'(push_c);
            valid  <= (after_pop_c != '0) || push_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (after_pop_c != '0) begin
                head <= mem[rd_next_c];
            end else if (push_c) begin
                head <= push_data;
            end
        end
    end

    assign level = count;

endmodule

// File: rtl/entropy_harvester.sv
// Synchronizes a metastable entropy bit, debiases it with a von Neumann
// extractor, whitens 16-bit words with the LFSR and buffers them.
module entropy_harvester
    import entropy_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           lfsr_in,
    input  logic                       raw_bit,
    entropy_harvester_if.master        bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned REP_W = 16;

    logic             sync1;
    logic             s;
    logic             s_prev;
    ext_state_t       state;
    logic             b0;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] bit_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             health_fail;
    logic             fifo_valid;

    logic             emit_c;
    logic             last_bit_c;
    logic             fail_det_c;
    logic             fail_now_c;
    logic [REP_W-1:0] rep_next_c;

    // Repetition count over synchronized samples; failure detected this cycle
    // takes effect immediately so a coincident word completion is discarded.
    always_comb begin
        rep_next_c = rep_cnt;
        if (s != s_prev) begin
            rep_next_c = REP_W'(1);
        end else if (rep_cnt < REP_W'(REP_LIMIT)) begin
            rep_next_c = rep_cnt + REP_W'(1);
        end
        fail_det_c = (rep_next_c == REP_W'(REP_LIMIT));
        fail_now_c = health_fail || fail_det_c;
        emit_c     = !fail_now_c && (state == ST_SECOND) && (s != b0);
        last_bit_c = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            s           <= 1'b0;
            s_prev      <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            state       <= ST_FIRST;
            b0          <= 1'b0;
            acc         <= '0;
            bit_cnt     <= '0;
            word_valid  <= 1'b0;
            word_data   <= '0;
        end else begin
            sync1      <= raw_bit;
            s          <= sync1;
            s_prev     <= s;
            rep_cnt    <= rep_next_c;
            word_valid <= 1'b0;
            if (fail_det_c) begin
                health_fail <= 1'b1;
            end
            if (fail_now_c) begin
                state   <= ST_FIRST;
                bit_cnt <= '0;
            end else if (state == ST_FIRST) begin
                b0    <= s;
                state <= ST_SECOND;
            end else begin
                state <= ST_FIRST;
                if (emit_c) begin
                    acc <= {acc[WIDTH-2:0], b0};
                    if (last_bit_c) begin
                        bit_cnt    <= '0;
                        word_valid <= 1'b1;
                        word_data  <= {acc[WIDTH-2:0], b0} ^ lfsr_in;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (word_valid),
        .push_data (word_data),
        .pop       (fifo_valid && bus.out_ready),
        .flush     (fail_now_c),
        .head      (bus.out_data),
        .valid     (fifo_valid),
        .level     (bus.fifo_level),
        .drop      (bus.drop_pulse)
    );

    assign bus.out_valid   = fifo_valid;
    assign bus.health_fail = health_fail;

endmodule

// File: tb/tb_entropy_harvester.sv
// Randomized and directed bench for entropy_harvester against a
// sample-stream reference model.
module tb_entropy_harvester;

    localparam int unsigned W   = 16;
    localparam int unsigned D   = 4;
    localparam int unsigned LIM = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] lfsr_in = '0;
    logic         raw_bit = 1'b0;

    entropy_harvester_if #(.WIDTH(W), .LEVEL_W(3)) bus ();

    entropy_harvester #(
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .REP_LIMIT  (LIM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lfsr_in (lfsr_in),
        .raw_bit (raw_bit),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit           hist[$];
    bit           m_prev_s;
    int           m_run;
    bit           m_fail;
    bit           m_second;
    bit           m_b0;
    int           m_nbits;
    logic [W-1:0] m_word;
    bit           m_pend_v;
    logic [W-1:0] m_pend_w;
    logic [W-1:0] q[$];
    logic [W-1:0] m_data;
    bit           m_drop;

    int drops_seen;
    int full_swaps;
    int max_level;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        m_prev_s = 0; m_run = 0; m_fail = 0; m_second = 0; m_b0 = 0;
        m_nbits = 0; m_word = '0; m_pend_v = 0; m_pend_w = '0;
        q.delete(); m_data = '0; m_drop = 0;
    endtask

    // Advances the model by one clock edge given the inputs present before it.
    task automatic model_edge(input bit raw, input logic [W-1:0] lfsr, input bit rdy);
        bit s;
        bit pop;
        bit fail_now;
        s = hist[hist.size() - 2];
        hist.push_back(raw);
        if (hist.size() > 4) void'(hist.pop_front());
        if (s == m_prev_s) begin
            if (m_run < LIM) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev_s = s;
        fail_now = m_fail || (m_run >= LIM);
        pop = (q.size() > 0) && rdy;
        m_drop = 0;
        if (fail_now) begin
            m_fail = 1; q.delete(); m_pend_v = 0; m_second = 0; m_nbits = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_pend_v) begin
                if (q.size() < D) q.push_back(m_pend_w);
                else m_drop = 1;
            end
            m_pend_v = 0;
            if (!m_second) begin
                m_b0 = s; m_second = 1;
            end else begin
                m_second = 0;
                if (s != m_b0) begin
                    m_word = {m_word[W-2:0], m_b0};
                    m_nbits++;
                    if (m_nbits == W) begin
                        m_nbits = 0; m_pend_v = 1; m_pend_w = m_word ^ lfsr;
                    end
                end
            end
        end
        if (q.size() > 0) m_data = q[0];
    endtask

    task automatic compare_all();
        check("out_valid", bus.out_valid, (q.size() > 0) ? 1 : 0);
        check("fifo_level", bus.fifo_level, q.size());
        check("out_data", bus.out_data, m_data);
        check("health_fail", bus.health_fail, m_fail);
        check("drop_pulse", bus.drop_pulse, m_drop);
        if (m_drop) drops_seen++;
        if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
    endtask

    task automatic step(input bit raw, input logic [W-1:0] lfsr, input bit rdy);
        @(negedge clk);
        raw_bit = raw; lfsr_in = lfsr; bus.out_ready = rdy;
        if (rdy && m_pend_v && q.size() == D && !m_fail) full_swaps++;
        model_edge(raw, lfsr, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; raw_bit = 1'b0; lfsr_in = '0; bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_fail", bus.health_fail, 0);
        check("rst_drop", bus.drop_pulse, 0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        bit raw;
        bit prev;
        int hold;
        bus.out_ready = 1'b0;
        model_reset();
        reset_dut();

        // Alternating 0,1 with zero LFSR: all-zero word.
        for (int i = 0; i < 40; i++) step(i[0], 16'h0000, 1'b0);
        check("alt01_level", bus.fifo_level, 1);
        check("alt01_data", bus.out_data, 16'h0000);

        // 1,0 pairs whitened with A5A5, consumer always ready.
        reset_dut();
        max_level = 0;
        for (int i = 0; i < 160; i++) step(~i[0], 16'hA5A5, 1'b1);
        check("a5_max_level", (max_level <= 1) ? 1 : 0, 1);

        // 1,0,0,1 stream with no consumer: fill to depth, then drop.
        reset_dut();
        drops_seen = 0;
        for (int i = 0; i < 200; i++) step((i % 4 == 0) || (i % 4 == 3), 16'h0000, 1'b0);
        check("fill_level", bus.fifo_level, D);
        check("fill_head", bus.out_data, 16'hAAAA);
        check("fill_dropped", (drops_seen > 0) ? 1 : 0, 1);

        // Pop only when a push meets a full FIFO.
        full_swaps = 0;
        drops_seen = 0;
        for (int i = 0; i < 200; i++)
            step((i % 4 == 0) || (i % 4 == 3), 16'h1234,
                 (m_pend_v && q.size() == D) ? 1'b1 : 1'b0);
        check("swap_seen", (full_swaps > 0) ? 1 : 0, 1);
        check("swap_nodrop", drops_seen, 0);

        // Constant 00/11 pairs never emit.
        reset_dut();
        for (int i = 0; i < 120; i++) step(i[1], 16'hFFFF, 1'b1);
        check("const_pairs_level", bus.fifo_level, 0);

        // Stuck source after two buffered words.
        reset_dut();
        for (int i = 0; i < 80; i++) step(~i[0], 16'h0F0F, 1'b0);
        check("pre_fail_level", bus.fifo_level, 2);
        for (int i = 0; i < LIM + 4; i++) step(1'b1, 16'h0F0F, 1'b0);
        check("stuck_fail", bus.health_fail, 1);
        for (int i = 0; i < 60; i++) step(i[0], $urandom, 1'b1);
        check("stuck_sticky", bus.health_fail, 1);
        check("stuck_valid", bus.out_valid, 0);
        reset_dut();

        // Randomized stream with bursts, random LFSR and backpressure.
        prev = 0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_dut();
            if (hold > 0) begin
                raw = prev;
                hold--;
            end else begin
                raw = 1'($urandom);
                if ($urandom_range(0, 19) == 0) hold = $urandom_range(3, 30);
            end
            prev = raw;
            step(raw, 16'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/entropy_harvester.md
Name: entropy_harvester

Overview:
Downstream consumer of the 16-bit randomized LFSR and its metastable destabilizer bit. It synchronizes the raw metastable bit and debiases it with a von Neumann extractor. Each 16 debiased bits are assembled into a word, XOR-whitened with the current LFSR output and buffered in a small FIFO behind a valid/ready interface. A repetition-count health test latches a failure flag and stops output if the entropy source sticks.

Parameters:
WIDTH, 16, word width; must equal the LFSR width.
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
REP_LIMIT, 64, consecutive identical synchronized samples that declare source failure; 2..65535.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
lfsr_in  input  WIDTH  parallel LFSR state, sampled at word completion
raw_bit  input  1  asynchronous metastable entropy bit
out_ready  input  1  consumer accepts the head word this cycle
out_data  output  WIDTH  FIFO head word (first-word fall-through)
out_valid  output  1  FIFO non-empty and no health failure
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
health_fail  output  1  sticky source-failure flag
drop_pulse  output  1  one-cycle pulse when a completed word is discarded because the FIFO is full

Behaviour:
- Reset: sync flops, accumulator, bit counter, rep counter and FIFO pointers are cleared. Extractor FSM goes to FIRST. All outputs are 0, including out_data.
- Synchronizer: 2 flops on raw_bit. Call the synchronized sample s; it lags raw_bit by 2 cycles.
- Extractor FSM, one sample per cycle:
  - FIRST: store b0 = s, go to SECOND.
  - SECOND: if s != b0, emit bit b0 (01 -> 0, 10 -> 1); otherwise discard the pair (00, 11). Always return to FIRST.
- Assembly:
  - An emitted bit shifts into the accumulator LSB (acc <= {acc[WIDTH-2:0], bit}); the bit counter increments.
  - On the cycle the counter would reach WIDTH, the completed word = {acc[WIDTH-2:0], bit} XOR lfsr_in sampled that same cycle.
  - That word is pushed and the counter wraps to 0. The accumulator is not cleared, because it is fully overwritten before the next push.
- FIFO:
  - A push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_pulse=1 for that cycle.
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop: level is unchanged and both take effect.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - When level is 0, out_data holds its last value and out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Health test:
  - The rep counter resets to 1 when s differs from the previous s, otherwise it increments, saturating at REP_LIMIT.
  - When it reaches REP_LIMIT, health_fail is set that cycle's next edge and stays set until rst.
  - While health_fail=1:
    - the FIFO is flushed (level 0) and out_valid=0;
    - no push occurs and drop_pulse=0;
    - the FSM is held in FIRST and the bit counter is held at 0.
  - If failure and a word completion fall in the same cycle, failure wins and the word is discarded without drop_pulse.
- Reset mid-operation: rst dominates everything. Partial words and FIFO contents are lost; health_fail is cleared.
- Latency: a raw pair change reaches the accumulator 3 cycles later (2 sync + FSM). A word completed at edge N is visible on out_data/out_valid after edge N+1.

Decomposition:
- Shared package entropy_pkg: default WIDTH/FIFO_DEPTH/REP_LIMIT constants and the extractor state enum (ST_FIRST, ST_SECOND).
- Natural sub-module: sync_fifo (parameterized WIDTH/DEPTH, push/pop/flush, level, first-word fall-through), reusable by other RNG consumers.
- The synchronizer, extractor, assembler and health test stay in entropy_harvester.

Test Plan:
- Reset, then raw_bit alternating 0,1 every cycle with lfsr_in=16'h0000 -> s pairs (0,1) emit 0; after 16 emitted bits, out_data=16'h0000, out_valid=1, fifo_level=1.
- raw_bit pattern 1,0 pairs, lfsr_in=16'hA5A5, out_ready=1 -> words 16'hFFFF^16'hA5A5=16'h5A5A, each popped the cycle after it appears; fifo_level never exceeds 1.
- Pair stream 1,0 then 0,1 alternating (1,0,0,1,...), out_ready=0, FIFO_DEPTH=4, lfsr_in=16'h0000 -> 4 words 16'hAAAA, then the 5th completion gives drop_pulse=1 and fifo_level stays 4.
- raw_bit held 1 for REP_LIMIT+2 cycles after 2 buffered words -> health_fail=1, fifo_level=0, out_valid=0; it stays so despite resumed toggling until rst, after which all outputs are 0.
- FIFO full and out_ready=1 on the same cycle a word completes -> no drop_pulse, fifo_level stays 4, the head advances.
- raw_bit constant 00 and 11 pairs shorter than REP_LIMIT -> no bits emitted, bit counter unchanged, out_valid stays 0.
